counter_core: RTL

Counting core of the safe binary counter. It sits directly downstream of the reset synchronizer and takes that synchronizer's output, inverted to an active-high synchronous reset. It advances a WIDTH-bit count on a prescaled auto-tick or on a debounced pushbutton step, up or down. The count drives the board LEDs.

---
 rtl/counter_core.sv | 120 ++++++++++++
 1 files changed

// File: rtl/counter_core.sv
// Counting core: button sync + debounce, prescaled auto-tick, up/down WIDTH-bit count.
// Define COUNTER_SATURATE_EN to clamp at the limits instead of wrapping; wrap then flags a blocked advance.
module counter_core #(
  parameter int WIDTH           = 8,
  parameter int DIV             = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             btn_raw,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap
);

  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
  localparam logic [DBW-1:0]   DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX    = '1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d, level_dly_q;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             step, advance;

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Level flips only on the edge that completes a full run of mismatching cycles.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end
  end

  assign step    = level_q & ~level_dly_q;
  assign advance = tick_q | step;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (advance) begin
      if (dir) begin
        if (count_q == CNT_MAX) begin
          wrap_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
          count_d = count_q;
`else
          count_d = '0;
`endif
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          wrap_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
          count_d = count_q;
`else
          count_d = CNT_MAX;
`endif
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      db_cnt_q    <= '0;
      presc_q     <= '0;
      tick_q      <= 1'b0;
      count_q     <= '0;
      wrap_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      db_cnt_q    <= db_cnt_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      count_q     <= count_d;
      wrap_q      <= wrap_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule
